param_rd_arbiter: RTL and testbench
===================================

Name: param_rd_arbiter

Overview:
Owns the per-layer parameter register file and serves reads to several consumers: param_module, the IBRAM read controller, and the second input write controller. The input write controller loads the file through a write port. Once loading completes, requester address channels are arbitrated round-robin onto the single read path. Each requester gets its data back on its own valid/ready data channel.

Parameters:
NUM_REQ, 3, number of read requesters (2..8)
MAX_NUM_LAYERS, 4, parameter entries (depth of register file)
PARAM_WIDTH, 26, bits per entry
ADDR_W, $clog2(MAX_NUM_LAYERS)+1, address width; the extra bit allows out-of-range detection

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe from input write controller
wr_addr  in  ADDR_W  write entry index
wr_data  in  PARAM_WIDTH  write entry value
load_done  in  1  single-cycle pulse: file complete, enable reads
clear  in  1  synchronous return to unloaded
params_loaded  out  1  high while reads enabled
req_addr  in  NUM_REQ*ADDR_W  packed requester addresses; requester i at [i*ADDR_W +: ADDR_W]
req_addr_valid  in  NUM_REQ  address valid per requester
req_addr_ready  out  NUM_REQ  address accepted (grant) per requester
rsp_data  out  NUM_REQ*PARAM_WIDTH  packed response data
rsp_err  out  NUM_REQ  response carries out-of-range address
rsp_data_valid  out  NUM_REQ  response valid per requester
rsp_data_ready  in  NUM_REQ  response consumed per requester

Behaviour:
- Reset is asynchronous and active-low (rst_n); clock is clk. On reset:
  - all outputs 0;
  - storage 0;
  - state UNLOADED;
  - rr_ptr 0.
- State UNLOADED:
  - req_addr_ready = 0; params_loaded = 0.
  - load_done moves the state to LOADED on the next edge.
- State LOADED:
  - params_loaded = 1.
  - load_done has no effect.
- clear (either state), next edge:
  - state to UNLOADED, storage zeroed, rr_ptr 0;
  - every rsp_data_valid dropped, even if not yet consumed.
  - clear beats a simultaneous load_done or wr_en.
- Writes (either state): with wr_en and wr_addr < MAX_NUM_LAYERS, the entry updates on the next edge. Out-of-range writes are ignored.
- Eligibility: requester i is eligible when all hold:
  - state is LOADED;
  - req_addr_valid[i];
  - rsp_data_valid[i] == 0 (one outstanding response per requester, no same-cycle bypass);
  - wr_en == 0 (writes have priority and stall all grants that cycle).
- Grant (combinational):
  - exactly one eligible requester is granted: the first found searching upward from rr_ptr, wrapping modulo NUM_REQ;
  - req_addr_ready is one-hot or zero;
  - ready may depend on valid.
- On an accepted request (valid & ready), next edge:
  - rr_ptr = granted index + 1 (mod NUM_REQ);
  - rsp_data_valid[i] = 1;
  - rsp_data[i] = storage[addr] (old value if the same edge writes that entry; not possible since wr_en stalls grants);
  - rsp_err[i] = (addr >= MAX_NUM_LAYERS), with data 0 when set.
  - Latency is 1 cycle from acceptance to valid.
- Response hold: rsp_data[i] and rsp_err[i] stay stable while valid and not ready. valid clears on the edge where ready is high.
- Throughput: aggregate one grant per cycle; per requester one grant per 2 cycles when ready is held high.
- No eligible requester: rr_ptr holds.

Optional Feature:
PARAM_RD_STATS_EN
- Defined:
  - adds output grant_count [NUM_REQ*16]: per-requester saturating grant counters at 16'hFFFF;
  - incremented on each acceptance;
  - zeroed by reset and clear.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package param_arb_pkg holds:
  - state enum {UNLOADED, LOADED};
  - localparams for bit-field offsets of PARAM_WIDTH entries (in_chan_size 6b, in_seq_length 8b, kernel_size 3b), shared with consumers.
- Sub-module rr_arbiter (NUM_REQ), wholly owned by this block:
  - inputs: request vector, advance strobe;
  - output: one-hot grant;
  - holds rr_ptr.
- Storage, response slots and FSM live in param_rd_arbiter.

Test Plan:
1. Load path: write entries 0..3 = 26'h1,2,3,4, then pulse load_done; req0 addr 2 → params_loaded=1 the next cycle, rsp_data[0]=26'h3 with rsp_err=0 one cycle after acceptance.
2. Round-robin under contention: all 3 requesters valid continuously with rsp_data_ready=1 → grants rotate 0,1,2,0,… with no requester granted twice within 3 consecutive grants.
3. Out-of-range: req1 addr 3'd5 → rsp_err[1]=1, rsp_data[1]=0; requester 1 is not granted again until its response is consumed.
4. Backpressure: req2 response held with ready=0 for 5 cycles → data stable; req2 new address not accepted; req0 and req1 still granted.
5. Write stall and clear: wr_en pulses while all requesters are valid → req_addr_ready=0 that cycle. Then clear with two responses pending → both rsp_data_valid go to 0, params_loaded=0, and a subsequent read of entry 0 returns 0 after reload.

Source files
------------

// File: rtl/param_arb_pkg.sv
// Shared types and field layout for the per-layer parameter file.
// The entry bit-field offsets are also used by the consumers that decode entries.
package param_arb_pkg;

    typedef enum logic {
        UNLOADED = 1'b0,
        LOADED   = 1'b1
    } arb_state_e;

    // Field layout of one parameter entry (LSB-first).
    localparam int IN_CHAN_SIZE_LSB  = 0;
    localparam int IN_CHAN_SIZE_W    = 6;
    localparam int IN_SEQ_LENGTH_LSB = IN_CHAN_SIZE_LSB + IN_CHAN_SIZE_W;
    localparam int IN_SEQ_LENGTH_W   = 8;
    localparam int KERNEL_SIZE_LSB   = IN_SEQ_LENGTH_LSB + IN_SEQ_LENGTH_W;
    localparam int KERNEL_SIZE_W     = 3;

    // Index following idx, wrapping modulo n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/param_rd_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above rr_ptr (wrapping),
// and moves rr_ptr past the winner when the grant is taken.
module rr_arbiter
    import param_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               advance_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             found;
    int               gnt_idx;
    int               scan_idx;

    // Scan upward from rr_ptr and pick the first active request.
    always_comb begin
        grant_o  = '0;
        found    = 1'b0;
        gnt_idx  = 0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && req_i[scan_idx]) begin
                found             = 1'b1;
                gnt_idx           = scan_idx;
                grant_o[scan_idx] = 1'b1;
            end
        end
    end

    // Pointer update; clear wins over an advance in the same cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (clear_i) begin
            rr_ptr_d = '0;
        end else if (advance_i && found) begin
            rr_ptr_d = PTR_W'(rr_next(gnt_idx, NUM_REQ));
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/param_rd_arbiter.sv
// Per-layer parameter register file with round-robin read service.
// The write port loads entries; after load_done the requesters' address
// channels are arbitrated onto one read path, each requester receiving its
// data one cycle later on its own valid/ready channel.
// Optional build macro PARAM_RD_STATS_EN adds per-requester saturating grant counters.
//
// state    | meaning
// UNLOADED | file being loaded, no reads granted
// LOADED   | reads enabled, params_loaded high
module param_rd_arbiter
    import param_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int MAX_NUM_LAYERS = 4,
    parameter int PARAM_WIDTH    = 26,
    parameter int ADDR_W         = $clog2(MAX_NUM_LAYERS) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [PARAM_WIDTH-1:0]         wr_data,
    input  logic                           load_done,
    input  logic                           clear,
    output logic                           params_loaded,
`ifdef PARAM_RD_STATS_EN
    output logic [NUM_REQ*16-1:0]          grant_count,
`endif
    input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ-1:0]             req_addr_valid,
    output logic [NUM_REQ-1:0]             req_addr_ready,
    output logic [NUM_REQ*PARAM_WIDTH-1:0] rsp_data,
    output logic [NUM_REQ-1:0]             rsp_err,
    output logic [NUM_REQ-1:0]             rsp_data_valid,
    input  logic [NUM_REQ-1:0]             rsp_data_ready
);

    localparam int IDX_W = (MAX_NUM_LAYERS > 1) ? $clog2(MAX_NUM_LAYERS) : 1;
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MAX_NUM_LAYERS);

    arb_state_e state_q, state_d;
    logic       rd_enable;

    logic [PARAM_WIDTH-1:0] mem_q [MAX_NUM_LAYERS];

    logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]             rsp_err_q, rsp_err_d;
    logic [NUM_REQ*PARAM_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  sel_addr;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNLOADED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear dominates load_done.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = UNLOADED;
        end else if (state_q == UNLOADED && load_done) begin
            state_d = LOADED;
        end
    end

    // State outputs.
    always_comb begin
        rd_enable     = (state_q == LOADED);
        params_loaded = rd_enable;
    end

    // Parameter storage; clear zeroes it and beats a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < MAX_NUM_LAYERS; e++) begin
                mem_q[e] <= '0;
            end
        end else if (clear) begin
            for (int e = 0; e < MAX_NUM_LAYERS; e++) begin
                mem_q[e] <= '0;
            end
        end else if (wr_en && (wr_addr < DEPTH)) begin
            mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Eligibility: loaded, requesting, no response outstanding, no write this cycle.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = rd_enable && req_addr_valid[i] && !rsp_valid_q[i] && !wr_en;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .advance_i (|grant),
        .req_i     (eligible),
        .grant_o   (grant)
    );

    assign req_addr_ready = grant;

    // Response slots: load on grant, release on consume, drop everything on clear.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        sel_addr    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            if (clear) begin
                rsp_valid_d[i]                          = 1'b0;
                rsp_err_d[i]                            = 1'b0;
                rsp_data_d[i*PARAM_WIDTH +: PARAM_WIDTH] = '0;
            end else if (grant[i]) begin
                rsp_valid_d[i] = 1'b1;
                if (sel_addr < DEPTH) begin
                    rsp_err_d[i]                            = 1'b0;
                    rsp_data_d[i*PARAM_WIDTH +: PARAM_WIDTH] = mem_q[sel_addr[IDX_W-1:0]];
                end else begin
                    rsp_err_d[i]                            = 1'b1;
                    rsp_data_d[i*PARAM_WIDTH +: PARAM_WIDTH] = '0;
                end
            end else if (rsp_valid_q[i] && rsp_data_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    // Response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_data_valid = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_data       = rsp_data_q;

`ifdef PARAM_RD_STATS_EN
    logic [NUM_REQ*16-1:0] cnt_q, cnt_d;

    // Saturating grant counters, zeroed by clear.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (clear) begin
                cnt_d[i*16 +: 16] = '0;
            end else if (grant[i] && (cnt_q[i*16 +: 16] != 16'hFFFF)) begin
                cnt_d[i*16 +: 16] = cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_param_rd_arbiter.sv
// Directed bench for param_rd_arbiter: load, round-robin, out-of-range,
// backpressure, write stall and clear.
module tb_param_rd_arbiter;

    localparam int NR = 3;
    localparam int ML = 4;
    localparam int PW = 26;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [PW-1:0]     wr_data;
    logic              load_done;
    logic              clear;
    logic              params_loaded;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_addr_valid;
    logic [NR-1:0]     req_addr_ready;
    logic [NR*PW-1:0]  rsp_data;
    logic [NR-1:0]     rsp_err;
    logic [NR-1:0]     rsp_data_valid;
    logic [NR-1:0]     rsp_data_ready;
`ifdef PARAM_RD_STATS_EN
    logic [NR*16-1:0]  grant_count;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    param_rd_arbiter #(
        .NUM_REQ        (NR),
        .MAX_NUM_LAYERS (ML),
        .PARAM_WIDTH    (PW),
        .ADDR_W         (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .load_done      (load_done),
        .clear          (clear),
        .params_loaded  (params_loaded),
`ifdef PARAM_RD_STATS_EN
        .grant_count    (grant_count),
`endif
        .req_addr       (req_addr),
        .req_addr_valid (req_addr_valid),
        .req_addr_ready (req_addr_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .rsp_data_valid (rsp_data_valid),
        .rsp_data_ready (rsp_data_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [PW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
    endtask

    function automatic logic [PW-1:0] dat(input int i);
        return rsp_data[i*PW +: PW];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] exp_g [6];
        logic [PW-1:0] exp_d [6];
        int            exp_i [6];

        rst_n          = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        load_done      = 1'b0;
        clear          = 1'b0;
        req_addr       = '0;
        req_addr_valid = '1;
        rsp_data_ready = '0;

        // Reset values
        #12;
        chk("rst params_loaded", params_loaded, 1'b0);
        chk("rst ready", req_addr_ready, 3'b000);
        chk("rst rsp_valid", rsp_data_valid, 3'b000);
        chk("rst rsp_err", rsp_err, 3'b000);
        chk("rst rsp_data", rsp_data, '0);
        @(negedge clk);
        req_addr_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Load path; final out-of-range write must be dropped, not alias entry 1
        wr(3'd0, 26'h1);
        wr(3'd1, 26'h2);
        wr(3'd2, 26'h3);
        wr(3'd3, 26'h4);
        wr(3'd5, 26'h3FFFFFF);
        req_addr       = {3'd0, 3'd0, 3'd2};
        req_addr_valid = 3'b001;
        #1;
        chk("unloaded ready", req_addr_ready, 3'b000);
        chk("unloaded params_loaded", params_loaded, 1'b0);
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        #1;
        chk("load params_loaded", params_loaded, 1'b1);
        chk("load grant0", req_addr_ready, 3'b001);
        cyc();
        chk("load rsp_valid", rsp_data_valid, 3'b001);
        chk("load rsp_data0", dat(0), 26'h3);
        chk("load rsp_err", rsp_err, 3'b000);
        chk("outstanding blocks ready", req_addr_ready, 3'b000);
        req_addr_valid = 3'b000;
        rsp_data_ready = 3'b001;
        cyc();
        chk("consume rsp_valid", rsp_data_valid, 3'b000);

        // 2. Round-robin, rr_ptr starts at 1
        req_addr       = {3'd3, 3'd1, 3'd0};
        req_addr_valid = 3'b111;
        rsp_data_ready = 3'b111;
        exp_g = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        exp_i = '{1, 2, 0, 1, 2, 0};
        exp_d = '{26'h2, 26'h4, 26'h1, 26'h2, 26'h4, 26'h1};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr grant%0d", k), req_addr_ready, exp_g[k]);
            if (k > 0) begin
                chk($sformatf("rr valid%0d", k), rsp_data_valid, exp_g[k-1]);
                chk($sformatf("rr data%0d", k), dat(exp_i[k-1]), exp_d[k-1]);
            end
            cyc();
        end
        chk("rr last valid", rsp_data_valid, 3'b001);
        chk("rr last data", dat(0), 26'h1);
        req_addr_valid = 3'b000;
        cyc();

        // 3. Out-of-range read by requester 1 (rr_ptr = 1)
        req_addr       = {3'd0, 3'd5, 3'd0};
        req_addr_valid = 3'b010;
        rsp_data_ready = 3'b000;
        #1;
        chk("oor grant", req_addr_ready, 3'b010);
        cyc();
        chk("oor valid", rsp_data_valid, 3'b010);
        chk("oor err", rsp_err, 3'b010);
        chk("oor data", dat(1), 26'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("oor held ready%0d", k), req_addr_ready, 3'b000);
            cyc();
        end
        rsp_data_ready = 3'b010;
        #1;
        chk("oor consume cycle ready", req_addr_ready, 3'b000);
        cyc();
        chk("oor regrant", req_addr_ready, 3'b010);
        req_addr_valid = 3'b000;
        rsp_data_ready = 3'b000;
        #1;
        cyc();

        // 4. Backpressure on requester 2 (rr_ptr = 2)
        req_addr       = {3'd2, 3'd0, 3'd1};
        req_addr_valid = 3'b100;
        #1;
        chk("bp grant2", req_addr_ready, 3'b100);
        cyc();
        chk("bp valid2", rsp_data_valid, 3'b100);
        chk("bp data2", dat(2), 26'h3);
        req_addr_valid = 3'b111;
        rsp_data_ready = 3'b011;
        exp_g = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b000};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp grant%0d", k), req_addr_ready, exp_g[k]);
            chk($sformatf("bp hold data%0d", k), dat(2), 26'h3);
            chk($sformatf("bp hold valid%0d", k), rsp_data_valid[2], 1'b1);
            if (k > 0) begin
                chk($sformatf("bp other data%0d", k), dat(k % 2 == 1 ? 0 : 1),
                    (k % 2 == 1) ? 26'h2 : 26'h1);
            end
            cyc();
        end
        chk("bp final data2", dat(2), 26'h3);
        req_addr_valid = 3'b000;
        rsp_data_ready = 3'b111;
        cyc();
        chk("bp drained", rsp_data_valid, 3'b000);

        // 5. Write stall, then clear with two responses pending (rr_ptr = 1)
        req_addr       = {3'd0, 3'd0, 3'd0};
        req_addr_valid = 3'b111;
        wr_en          = 1'b1;
        wr_addr        = 3'd3;
        wr_data        = 26'h15;
        #1;
        chk("stall ready", req_addr_ready, 3'b000);
        cyc();
        wr_en          = 1'b0;
        req_addr_valid = 3'b101;
        rsp_data_ready = 3'b000;
        #1;
        chk("post-stall grant", req_addr_ready, 3'b100);
        cyc();
        chk("pend grant0", req_addr_ready, 3'b001);
        cyc();
        chk("pend valids", rsp_data_valid, 3'b101);
        clear     = 1'b1;
        load_done = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 3'd0;
        wr_data   = 26'h7;
        cyc();
        clear     = 1'b0;
        load_done = 1'b0;
        wr_en     = 1'b0;
        req_addr_valid = 3'b111;
        rsp_data_ready = 3'b111;
        #1;
        chk("clear valids", rsp_data_valid, 3'b000);
        chk("clear params_loaded", params_loaded, 1'b0);
        chk("clear ready", req_addr_ready, 3'b000);
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        req_addr  = {3'd0, 3'd3, 3'd0};
        #1;
        chk("reload params_loaded", params_loaded, 1'b1);
        chk("reload ptr reset grant", req_addr_ready, 3'b001);
        req_addr_valid = 3'b011;
        cyc();
        chk("reload valid0", rsp_data_valid, 3'b001);
        chk("reload data0", dat(0), 26'h0);
        req_addr_valid = 3'b010;
        #1;
        chk("reload grant1", req_addr_ready, 3'b010);
        cyc();
        chk("reload data entry3", dat(1), 26'h0);
        chk("reload err1", rsp_err[1], 1'b0);
        req_addr_valid = 3'b000;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
